// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - Y86 write-back stage: register file, status latch, retire counter
module wb_regfile #(
  parameter int DATA_WID = 64,
  parameter int RID_WID  = 4,
  parameter int CNT_WID  = 32
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                in_valid,
  input  logic [RID_WID-1:0]  dstE,
  input  logic [RID_WID-1:0]  dstM,
  input  logic [DATA_WID-1:0] valE,
  input  logic [DATA_WID-1:0] valM,
  input  logic [3:0]          stat,
  input  logic [RID_WID-1:0]  srcA,
  input  logic [RID_WID-1:0]  srcB,
  output logic [DATA_WID-1:0] valA,
  output logic [DATA_WID-1:0] valB,
  output logic [3:0]          cpu_stat,
  output logic                halted,
  output logic [CNT_WID-1:0]  retired
);

  localparam int                 NREG     = (1 << RID_WID) - 1;
  localparam logic [RID_WID-1:0] RNONE    = '1;
  localparam logic [3:0]         STAT_AOK = 4'h1;
  localparam logic [0:0]         S_RUN    = 1'b0;
  localparam logic [0:0]         S_HALTED = 1'b1;

  logic [DATA_WID-1:0] r_regs [0:NREG-1];
  logic [0:0]          r_state;
  logic [3:0]          r_cpu_stat;
  logic [CNT_WID-1:0]  r_retired;

  logic w_commit;
  logic w_aok;

  assign w_commit = in_valid && (r_state == S_RUN);
  assign w_aok    = (stat == STAT_AOK);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
      r_state    <= S_RUN;
      r_cpu_stat <= STAT_AOK;
      r_retired  <= '0;
    end else if (w_commit) begin
      if (w_aok) begin
        // M write is issued last so it wins when dstE == dstM (popq %rsp)
        if (dstE != RNONE) r_regs[dstE] <= valE;
        if (dstM != RNONE) r_regs[dstM] <= valM;
        r_retired <= r_retired + 1'b1;
      end else begin
        r_cpu_stat <= stat;
        r_state    <= S_HALTED;
      end
    end
  end

  assign valA     = (srcA == RNONE) ? '0 : r_regs[srcA];
  assign valB     = (srcB == RNONE) ? '0 : r_regs[srcB];
  assign cpu_stat = r_cpu_stat;
  assign halted   = (r_state == S_HALTED);
  assign retired  = r_retired;

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - directed self-checking bench for wb_regfile
module tb_wb_regfile;

  logic        CLK;
  logic        RST_N;
  logic        in_valid;
  logic [3:0]  dstE;
  logic [3:0]  dstM;
  logic [63:0] valE;
  logic [63:0] valM;
  logic [3:0]  stat;
  logic [3:0]  srcA;
  logic [3:0]  srcB;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [3:0]  cpu_stat;
  logic        halted;
  logic [31:0] retired;

  int n_cmp;
  int n_err;

  wb_regfile #(.DATA_WID(64), .RID_WID(4), .CNT_WID(32)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .in_valid (in_valid),
    .dstE     (dstE),
    .dstM     (dstM),
    .valE     (valE),
    .valM     (valM),
    .stat     (stat),
    .srcA     (srcA),
    .srcB     (srcB),
    .valA     (valA),
    .valB     (valB),
    .cpu_stat (cpu_stat),
    .halted   (halted),
    .retired  (retired)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // present one instruction, clock it in, then return to a bubble
  task automatic commit(input logic [3:0] de, input logic [63:0] ve,
                        input logic [3:0] dm, input logic [63:0] vm,
                        input logic [3:0] st);
    dstE = de; valE = ve; dstM = dm; valM = vm; stat = st;
    in_valid = 1'b1;
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic async_reset_pulse();
    @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    RST_N = 1'b0;
    in_valid = 1'b0;
    dstE = 4'hF; dstM = 4'hF; valE = '0; valM = '0; stat = 4'h1;
    srcA = 4'h0; srcB = 4'hE;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_valA", valA, 64'h0);
    chk("reset_valB", valB, 64'h0);
    chk("reset_cpu_stat", cpu_stat, 64'h1);
    chk("reset_halted", halted, 64'h0);
    chk("reset_retired", retired, 64'h0);
    @(negedge CLK);
    RST_N = 1'b1;

    // dual write, with same-cycle read showing pre-edge values
    @(posedge CLK); #1;
    srcA = 4'h2; srcB = 4'h3;
    dstE = 4'h2; valE = 64'h11; dstM = 4'h3; valM = 64'h22; stat = 4'h1;
    in_valid = 1'b1;
    #1;
    chk("dual_pre_valA", valA, 64'h0);
    chk("dual_pre_valB", valB, 64'h0);
    @(posedge CLK); #1;
    in_valid = 1'b0;
    chk("dual_valA", valA, 64'h11);
    chk("dual_valB", valB, 64'h22);
    chk("dual_retired", retired, 64'h1);

    // collision: valM wins
    commit(4'h4, 64'h08, 4'h4, 64'h40, 4'h1);
    srcA = 4'h4;
    #1;
    chk("collide_reg4", valA, 64'h40);
    chk("collide_retired", retired, 64'h2);
    @(posedge CLK); #1;
    chk("bubble_retired", retired, 64'h2);

    // RNONE destinations: no writes but counted
    commit(4'hF, 64'hAA, 4'hF, 64'hBB, 4'h1);
    srcA = 4'h2; srcB = 4'h4;
    #1;
    chk("rnone_retired", retired, 64'h3);
    chk("rnone_reg2", valA, 64'h11);
    chk("rnone_reg4", valB, 64'h40);
    srcA = 4'hF;
    #1;
    chk("rnone_read", valA, 64'h0);

    // ADR fault on a load: no write, halt
    commit(4'hF, 64'h0, 4'h5, 64'h77, 4'h3);
    srcA = 4'h5;
    #1;
    chk("fault_reg5", valA, 64'h0);
    chk("fault_cpu_stat", cpu_stat, 64'h3);
    chk("fault_halted", halted, 64'h1);
    chk("fault_retired", retired, 64'h3);
    commit(4'h6, 64'h55, 4'hF, 64'h0, 4'h1);
    srcA = 4'h6;
    #1;
    chk("frozen_reg6", valA, 64'h0);
    chk("frozen_retired", retired, 64'h3);
    chk("frozen_cpu_stat", cpu_stat, 64'h3);

    // async reset out of HALTED
    async_reset_pulse();
    srcA = 4'h2;
    #1;
    chk("areset1_halted", halted, 64'h0);
    chk("areset1_cpu_stat", cpu_stat, 64'h1);
    chk("areset1_retired", retired, 64'h0);
    chk("areset1_reg2", valA, 64'h0);
    RST_N = 1'b1;

    // HLT, then mid-cycle reset, then a normal write
    commit(4'h7, 64'h12, 4'hF, 64'h0, 4'h2);
    chk("hlt_halted", halted, 64'h1);
    chk("hlt_cpu_stat", cpu_stat, 64'h2);
    async_reset_pulse();
    chk("areset2_halted", halted, 64'h0);
    chk("areset2_cpu_stat", cpu_stat, 64'h1);
    RST_N = 1'b1;
    commit(4'h1, 64'h99, 4'hF, 64'h0, 4'h1);
    srcA = 4'h1;
    #1;
    chk("post_reset_reg1", valA, 64'h99);
    chk("post_reset_retired", retired, 64'h1);

    // illegal status code latched verbatim
    commit(4'h1, 64'h5A, 4'hF, 64'h0, 4'h0);
    chk("illegal_cpu_stat", cpu_stat, 64'h0);
    chk("illegal_halted", halted, 64'h1);
    chk("illegal_reg1", valA, 64'h99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and register file for the single-cycle Y86 datapath. Consumes the memory stage's outputs (valM, stat), together with valE and destination register IDs carried from execute. Commits them to the 15-entry program register file and latches the processor status, freezing architectural state on the first non-AOK status. Supplies the decode stage with valA/valB through two combinational read ports.

## Interface
- DATA_WID, 64, register/data width in bits
- RID_WID, 4, register ID width; ID 4'hF = RNONE
- CNT_WID, 32, retired-instruction counter width
- CLK  input  1  clock, all state updates on rising edge
- RST_N  input  1  reset, asynchronous, active-low
- in_valid  input  1  1 = an instruction is presented this cycle; 0 = bubble, no effect
- dstE  input  RID_WID  destination for valE (RNONE = no write)
- dstM  input  RID_WID  destination for valM (RNONE = no write)
- valE  input  DATA_WID  ALU result from execute
- valM  input  DATA_WID  load data from memory stage
- stat  input  4  status from memory stage: 1 AOK, 2 HLT, 3 ADR, 4 INS
- srcA, srcB  input  RID_WID  read-port register IDs
- valA, valB  output  DATA_WID  read-port data
- cpu_stat  output  4  architectural status
- halted  output  1  1 once a non-AOK status has been committed
- retired  output  CNT_WID  count of committed AOK instructions

## Operation
- Reset (RST_N low, asynchronous): all 15 registers = 0; cpu_stat = 1 (AOK); halted = 0; retired = 0; FSM = RUN. valA/valB read 0.
- FSM has two states:
  - RUN: a commit occurs when in_valid=1.
  - HALTED: entered from RUN on a commit with stat != AOK. Exited only by reset.
- Commit in RUN with stat == AOK:
  - if dstE != RNONE, reg[dstE] <= valE
  - if dstM != RNONE, reg[dstM] <= valM
  - retired <= retired + 1
- Same-register rule: dstE == dstM != RNONE → valM wins (popq %rsp semantics).
- Commit in RUN with stat != AOK: no register writes (ADR load and INS must not update state); retired unchanged; cpu_stat <= stat; halted <= 1; FSM → HALTED.
- in_valid=0 in RUN: nothing changes. Bubbles are not counted.
- HALTED: all inputs ignored; registers, cpu_stat, retired frozen.
- Read ports are combinational:
  - valA = reg[srcA], valB = reg[srcB]
  - src == RNONE → 0
  - no write-through: a read in the same cycle as a write returns the pre-edge value.
- Illegal stat codes (0, 5..15) are treated as non-AOK: latched verbatim and halt.
- retired wraps modulo 2^CNT_WID; no saturation.

## Timing
- Write latency 1 cycle: data committed at edge N is visible on valA/valB after edge N.
- cpu_stat/halted update at the same edge as the offending commit.
- Reset asserted mid-operation clears state immediately, independent of CLK. Deassertion takes effect at the next edge.
- No handshake back-pressure: the stage always accepts, one instruction per cycle.

## Test plan
- Reset: RST_N low → valA/valB (srcA=0, srcB=14) = 0, cpu_stat=1, halted=0, retired=0.
- Dual write: valid, stat=1, dstE=2 valE=0x11, dstM=3 valM=0x22 → after edge: srcA=2 gives 0x11, srcB=3 gives 0x22, retired=1. A same-cycle read before the edge returns 0.
- Collision: dstE=dstM=4, valE=0x08, valM=0x40 → reg4=0x40. A following bubble cycle leaves retired unchanged.
- Fault: dstM=5 valM=0x77 stat=3 → reg5 remains 0, cpu_stat=3, halted=1. A later AOK write to reg6 is ignored and retired is frozen.
- HLT then async reset mid-cycle: stat=2 → halted. Pulse RST_N low between edges → immediate clear; next AOK write to reg1=0x99 commits.
- RNONE: dstE=dstM=0xF, stat=1 → no register changes, retired increments; srcA=0xF reads 0.
